// File: rtl/mc_decoder.sv
// mc_decoder: multicycle control unit for the ARM-subset processor.
// Moore main FSM sequencing fetch/decode/execute/memory/writeback, plus ALU and instruction decode.
`default_nettype none

module mc_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic [3:0] state,
  output logic [1:0] FlagW,
  output logic       PCS,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t cur_state;
  state_t nxt_state;
  logic   alu_op;
  logic   branch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur_state <= FETCH;
    else       cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state = FETCH;
    alu_op    = 1'b0;
    branch    = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    case (cur_state)
      FETCH: begin
        nxt_state = DECODE;
        IRWrite   = 1'b1;
        NextPC    = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b01:   nxt_state = MEMADR;
          2'b00:   nxt_state = Funct[5] ? EXECI : EXECR;
          2'b10:   nxt_state = BRANCH;
          default: nxt_state = FETCH;
        endcase
      end
      MEMADR: begin
        nxt_state = Funct[0] ? MEMRD : MEMWR;
        ALUSrcB   = 2'b01;
      end
      MEMRD: begin
        nxt_state = MEMWB;
        AdrSrc    = 1'b1;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECR: begin
        nxt_state = ALUWB;
        alu_op    = 1'b1;
      end
      EXECI: begin
        nxt_state = ALUWB;
        ALUSrcB   = 2'b01;
        alu_op    = 1'b1;
      end
      ALUWB: begin
        RegW = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      // Unused codes fall back to FETCH with every output low.
      default: nxt_state = FETCH;
    endcase
  end

  always_comb begin
    ALUControl = 2'b00;
    FlagW      = 2'b00;
    if (alu_op) begin
      case (Funct[4:1])
        4'b0100: begin ALUControl = 2'b00; FlagW = {Funct[0], Funct[0]}; end
        4'b0010: begin ALUControl = 2'b01; FlagW = {Funct[0], Funct[0]}; end
        4'b0000: begin ALUControl = 2'b10; FlagW = {Funct[0], 1'b0}; end
        4'b1100: begin ALUControl = 2'b11; FlagW = {Funct[0], 1'b0}; end
        default: begin ALUControl = 2'b00; FlagW = 2'b00; end
      endcase
    end
  end

  assign state  = cur_state;
  assign PCS    = (RegW && (Rd == 4'b1111)) || branch;
  assign ImmSrc = Op;
  assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};

endmodule

`default_nettype wire

// File: tb/tb_mc_decoder.sv
// Scoreboard bench for mc_decoder: stimulus pushes per-cycle expectations, a monitor pops and compares.
`default_nettype none

module tb_mc_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'd0;
  logic [3:0] Rd = 4'd0;
  logic [3:0] state;
  logic [1:0] FlagW;
  logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;

  mc_decoder dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .state(state), .FlagW(FlagW), .PCS(PCS), .NextPC(NextPC), .RegW(RegW),
    .MemW(MemW), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .ALUControl(ALUControl)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [22:0] exp_q[$];
  int cyc = 0;

  // {state, FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl}
  function automatic logic [22:0] actual_vec();
    return {state, FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ResultSrc,
            ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl};
  endfunction

  // Expected outputs in a given state, taken straight from the per-state table.
  function automatic logic [22:0] exp_vec(int st, logic [1:0] op, logic [5:0] fn, logic [3:0] rd);
    logic [1:0] flagw = 0, rsrc = 0, bsrc = 0, aluc = 0;
    logic pcs = 0, npc = 0, regw = 0, memw = 0, irw = 0, adr = 0, asrc = 0, br = 0, aluop = 0;
    logic [1:0] regsrc;
    case (st)
      0: begin irw = 1; npc = 1; asrc = 1; bsrc = 2; rsrc = 2; end
      1: begin asrc = 1; bsrc = 2; rsrc = 2; end
      2: bsrc = 1;
      3: adr = 1;
      4: begin rsrc = 1; regw = 1; end
      5: begin adr = 1; memw = 1; end
      6: aluop = 1;
      7: begin bsrc = 1; aluop = 1; end
      8: regw = 1;
      9: begin bsrc = 1; rsrc = 2; br = 1; end
      default: ;
    endcase
    if (aluop) begin
      int cmd = int'(fn[4:1]);
      if (cmd == 4)       begin aluc = 0; flagw = {fn[0], fn[0]}; end
      else if (cmd == 2)  begin aluc = 1; flagw = {fn[0], fn[0]}; end
      else if (cmd == 0)  begin aluc = 2; flagw = {fn[0], 1'b0}; end
      else if (cmd == 12) begin aluc = 3; flagw = {fn[0], 1'b0}; end
    end
    pcs = (regw && rd == 15) || br;
    regsrc[1] = (op == 1);
    regsrc[0] = (op == 2);
    return {4'(st), flagw, pcs, npc, regw, memw, irw, adr, rsrc, asrc, bsrc, op, regsrc, aluc};
  endfunction

  // Expected state walk of one instruction, FETCH through the state before returning to FETCH.
  function automatic void instr_seq(logic [1:0] op, logic [5:0] fn, ref int s[$]);
    s = {};
    case (op)
      2'b01:   s = fn[0] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
      2'b00:   s = fn[5] ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
      2'b10:   s = '{0, 1, 9};
      default: s = '{0, 1};
    endcase
  endfunction

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (exp_q.size() > 0) begin
      logic [22:0] e;
      logic [22:0] a;
      e = exp_q.pop_front();
      a = actual_vec();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs cyc=%0d state=%0d: actual=%h required=%h", cyc, e[22:19], a, e);
      end
    end
  end

  task automatic run_instr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd);
    int s[$];
    Op = op; Funct = fn; Rd = rd;
    instr_seq(op, fn, s);
    foreach (s[k]) begin
      exp_q.push_back(exp_vec(s[k], op, fn, rd));
      @(posedge clk); #1;
    end
  endtask

  task automatic push_idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(exp_vec(0, Op, Funct, Rd));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int wait_cnt;
    logic [1:0] op;
    logic [5:0] fn;
    logic [3:0] rd;
    logic [3:0] cmds [5];
    cmds[0] = 4'd4; cmds[1] = 4'd2; cmds[2] = 4'd0; cmds[3] = 4'd12; cmds[4] = 4'd0;

    @(posedge clk); #1;
    push_idle_cycles(2);
    reset = 1'b0;
    exp_q.push_back(exp_vec(0, Op, Funct, Rd));
    @(posedge clk); #1;
    // Released cycle already consumed FETCH; continue from DECODE of a first ADDS instruction.

    // Reset held for three cycles in the middle of EXECR.
    Op = 2'b00; Funct = 6'b001001; Rd = 4'd3;
    exp_q.push_back(exp_vec(1, Op, Funct, Rd));
    @(posedge clk); #1;
    exp_q.push_back(exp_vec(6, Op, Funct, Rd));
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0 || IRWrite !== 1'b1 || NextPC !== 1'b1 || RegW !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: actual state=%0d IRWrite=%b NextPC=%b RegW=%b required 0/1/1/0",
               state, IRWrite, NextPC, RegW);
    end
    @(posedge clk); #1;
    push_idle_cycles(3);
    reset = 1'b0;

    // Directed instructions.
    run_instr(2'b01, 6'b011001, 4'd5);   // LDR
    run_instr(2'b01, 6'b011000, 4'd5);   // STR
    run_instr(2'b00, 6'b001001, 4'd3);   // ADDS register
    run_instr(2'b00, 6'b111000, 4'd15);  // ORR immediate to R15
    run_instr(2'b10, 6'b000000, 4'd0);   // branch
    run_instr(2'b11, 6'b101010, 4'd15);  // undefined
    run_instr(2'b01, 6'b000001, 4'd15);  // LDR to PC
    run_instr(2'b00, 6'b000101, 4'd15);  // SUBS to PC
    run_instr(2'b00, 6'b010111, 4'd2);   // undefined cmd with S

    for (int n = 0; n < 250; n++) begin
      op = 2'($urandom_range(0, 3));
      fn = 6'($urandom);
      if ($urandom_range(0, 3) != 0) fn[4:1] = cmds[$urandom_range(0, 4)];
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      run_instr(op, fn, rd);
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 100) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: actual pending=%0d required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mc_decoder.md
# mc_decoder

Multicycle control unit for the ARM-subset processor: a Moore main FSM plus ALU and instruction decoders. It sequences each instruction through fetch, decode, execute, memory and writeback. It sits directly upstream of the conditional-execution logic, which consumes its unconditioned FlagW, PCS, RegW and MemW. It also drives every datapath mux and enable select for the shared-memory multicycle datapath.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces FETCH
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20] (I, cmd[3:0], S / L)
- Rd  in  4  Instr[15:12]
- state  out  4  current FSM state code (debug)
- FlagW  out  2  flag-write request, [1]=NZ, [0]=CV
- PCS  out  1  PC-write request (branch, or write to R15)
- NextPC  out  1  unconditional PC update (fetch)
- RegW  out  1  register-write request
- MemW  out  1  memory-write request
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  1  0=A register, 1=PC
- ALUSrcB  out  2  00=WriteData, 01=ExtImm, 10=constant 4
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR

## Operation
- State codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
- Transitions:
  - FETCH→DECODE.
  - DECODE: Op=01→MEMADR; Op=00 & Funct[5]=0→EXECR; Op=00 & Funct[5]=1→EXECI; Op=10→BRANCH; Op=11→FETCH (undefined op, no side effects).
  - MEMADR: Funct[0]=1→MEMRD, else MEMWR.
  - MEMRD→MEMWB→FETCH.
  - MEMWR→FETCH.
  - EXECR/EXECI→ALUWB→FETCH.
  - BRANCH→FETCH.
  - Codes 10–15→FETCH, with all outputs 0.
- Per-state outputs. Unlisted outputs are 0; ALUOp is internal.
  - FETCH: AdrSrc=0, IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
  - EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=1.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1.
- ALU decode:
  - ALUOp=0 → ALUControl=00, FlagW=00.
  - ALUOp=1 → Funct[4:1]: 0100→00, 0010→01, 0000→10, 1100→11, other→00 with FlagW=00.
  - FlagW[1]=Funct[0].
  - FlagW[0]=Funct[0] & (ADD|SUB).
- PCS = (RegW & Rd==1111) | Branch.
- ImmSrc and RegSrc are pure functions of Op, valid in every state.

## Timing
- Only the 4-bit state register is sequential. All outputs are combinational from state, Op, Funct and Rd; outputs settle within the same cycle.
- Reset asserted: state=0 immediately, no clock needed. Outputs take FETCH values: IRWrite=1, NextPC=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, all others 0.
- First transition occurs on the first rising edge after reset deasserts.
- Instruction latency in cycles, FETCH to return to FETCH:
  - LDR: 5
  - STR: 4
  - data-processing: 4
  - branch: 3
  - undefined (Op=11): 2
- Op, Funct and Rd are sampled only in DECODE and later states. The IR is held stable there because IRWrite=0.
- Reset mid-instruction aborts it. No RegW or MemW pulse is issued after reset asserts.
- RegW, MemW, PCS and FlagW are requests. Gating by the condition check is downstream; this block never sees flags.

## Test plan
- Reset held 3 cycles mid-EXECR, then released → state=0 during reset with IRWrite=1 and NextPC=1; DECODE one edge after release.
- LDR (Op=01, Funct=011001) → states 0,1,2,3,4,0. RegW=1 only in MEMWB with ResultSrc=01. MemW never asserted.
- STR (Op=01, Funct=011000) → states 0,1,2,5,0. MemW=1 and AdrSrc=1 only in MEMWR.
- ADDS register (Op=00, Funct=001001, Rd=0011) → states 0,1,6,8,0. In EXECR, ALUControl=00 and FlagW=11. RegW=1 in ALUWB with PCS=0.
- ORR immediate writing R15 (Op=00, Funct=111000, Rd=1111) → states 0,1,7,8. ALUControl=11 and FlagW=00. PCS=1 and RegW=1 in ALUWB.
- Branch (Op=10) → states 0,1,9,0. PCS=1, ALUSrcB=01 and ImmSrc=10 in BRANCH. Op=11 returns DECODE→FETCH with all write requests 0.
